timer_sequencer: RTL and testbench

Upstream controller for the countdown timer block. It holds a small programmable table of interval values and drives the timer's `enable`/`timer_load` pair to run those intervals back to back. It watches the timer's `timeout`, pulses a status strobe per completed interval, and can loop the table continuously. It gives firmware-facing logic a single start/stop handshake in place of per-interval timer management.

---
 rtl/timer_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_timer_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sequencer.sv
// timer_sequencer
//   Drives a countdown timer through a programmable table of intervals,
//   running them back to back. The table can optionally loop.
//
//   Ports
//     clk          clock
//     rst          synchronous, active-low reset
//     cfg_we       table write strobe (ignored while busy)
//     cfg_addr     table write index
//     cfg_data     interval value to write
//     count        number of active entries, sampled at start
//     repeat_mode  loop back to entry 0 after the last entry, sampled at start
//     start        one-cycle request to begin the sequence
//     stop         one-cycle abort request (beats start and tmr_timeout)
//     tmr_timeout  timeout from the timer
//     tmr_enable   to timer enable
//     tmr_load     to timer load value
//     busy         high in LOAD/RUN
//     step_idx     index of the current entry
//     step_done    one-cycle pulse per completed entry
//     seq_done     one-cycle pulse when a non-repeating sequence finishes
//     err          sticky overrun flag
//
//   Optional feature macro: TIMER_SEQ_OVERRUN_EN
//     Defined:   a saturating RUN-cycle counter aborts an entry that runs
//                more than tmr_load+2+GUARD cycles without a timeout and
//                sets err (cleared by reset or the next accepted start).
//     Undefined: no counter, err is tied to 0.
module timer_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GUARD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [WIDTH-1:0]         cfg_data,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic                     repeat_mode,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     tmr_timeout,
    output logic                     tmr_enable,
    output logic [WIDTH-1:0]         tmr_load,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     step_done,
    output logic                     seq_done,
    output logic                     err
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] tbl [DEPTH];
    logic [AW:0]      cnt_q;
    logic             rep_q;
    logic [AW-1:0]    idx_nxt;
    logic             last;
    logic             start_ok;

    always_comb begin
        idx_nxt  = step_idx + AW'(1);
        // Current entry is the last active one when idx+1 reaches the count.
        last     = ({1'b0, step_idx} + (AW+1)'(1)) >= cnt_q;
        start_ok = start && (count != '0) && (count <= DEPTH_C);
    end

`ifdef TIMER_SEQ_OVERRUN_EN
    logic [WIDTH:0] run_cnt;
    logic           overrun;

    // run_cnt holds the number of RUN cycles already completed, so the
    // abort fires on RUN cycle tmr_load+2+GUARD+1.
    always_comb begin
        overrun = ({1'b0, run_cnt} >= ({2'b00, tmr_load} + (WIDTH+2)'(GUARD + 2)));
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            tmr_enable <= 1'b0;
            tmr_load   <= '0;
            busy       <= 1'b0;
            step_idx   <= '0;
            step_done  <= 1'b0;
            seq_done   <= 1'b0;
            cnt_q      <= '0;
            rep_q      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
`ifdef TIMER_SEQ_OVERRUN_EN
            run_cnt    <= '0;
            err        <= 1'b0;
`endif
        end else begin
            step_done <= 1'b0;
            seq_done  <= 1'b0;

            if (cfg_we && state == S_IDLE) begin
                tbl[cfg_addr] <= cfg_data;
            end

            if (stop) begin
                state      <= S_IDLE;
                tmr_enable <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            state      <= S_LOAD;
                            step_idx   <= '0;
                            tmr_load   <= tbl[0];
                            cnt_q      <= count;
                            rep_q      <= repeat_mode;
                            busy       <= 1'b1;
                            tmr_enable <= 1'b0;
`ifdef TIMER_SEQ_OVERRUN_EN
                            err        <= 1'b0;
`endif
                        end
                    end
                    S_LOAD: begin
                        state      <= S_RUN;
                        tmr_enable <= 1'b1;
`ifdef TIMER_SEQ_OVERRUN_EN
                        run_cnt    <= '0;
`endif
                    end
                    S_RUN: begin
                        if (tmr_timeout) begin
                            step_done  <= 1'b1;
                            tmr_enable <= 1'b0;
                            if (!last) begin
                                state    <= S_LOAD;
                                step_idx <= idx_nxt;
                                tmr_load <= tbl[idx_nxt];
                            end else if (rep_q) begin
                                state    <= S_LOAD;
                                step_idx <= '0;
                                tmr_load <= tbl[0];
                            end else begin
                                state    <= S_IDLE;
                                seq_done <= 1'b1;
                                busy     <= 1'b0;
                            end
                        end
`ifdef TIMER_SEQ_OVERRUN_EN
                        else if (overrun) begin
                            state      <= S_IDLE;
                            tmr_enable <= 1'b0;
                            busy       <= 1'b0;
                            err        <= 1'b1;
                        end else if (run_cnt != '1) begin
                            run_cnt <= run_cnt + (WIDTH+1)'(1);
                        end
`endif
                    end
                    default: begin
                        state      <= S_IDLE;
                        tmr_enable <= 1'b0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer with a behavioural countdown timer
// attached (RUN lasts load+2 cycles). The timer can be replaced by a manually
// driven timeout for the abort and overrun cases.
module tb_timer_sequencer;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int GUARD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic [2:0]  count = '0;
    logic        repeat_mode = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        tmr_timeout;
    logic        tmr_enable;
    logic [31:0] tmr_load;
    logic        busy;
    logic [1:0]  step_idx;
    logic        step_done;
    logic        seq_done;
    logic        err;

    logic        use_model = 1'b1;
    logic        man_to = 1'b0;
    logic [31:0] tcnt = '0;
    logic        model_to;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    timer_sequencer #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .GUARD(GUARD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .count(count),
        .repeat_mode(repeat_mode),
        .start(start),
        .stop(stop),
        .tmr_timeout(tmr_timeout),
        .tmr_enable(tmr_enable),
        .tmr_load(tmr_load),
        .busy(busy),
        .step_idx(step_idx),
        .step_done(step_done),
        .seq_done(seq_done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Timer: captures load while disabled, times out on enabled cycle load+2.
    always @(posedge clk) begin
        if (!tmr_enable) tcnt <= '0;
        else             tcnt <= tcnt + 32'd1;
    end
    assign model_to    = tmr_enable && (tcnt == tmr_load + 32'd1);
    assign tmr_timeout = use_model ? model_to : man_to;

    typedef struct {
        logic        start;
        logic        stop;
        logic [2:0]  cnt;
        logic        rep;
        logic        busy;
        logic        en;
        logic [1:0]  idx;
        logic        chk_idx;
        logic        step;
        logic        seq;
        logic [31:0] load;
    } vec_t;

    vec_t rows[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic add(input int n, input logic st, input logic sp, input logic [2:0] c,
                       input logic r, input logic b, input logic e, input logic [1:0] i,
                       input logic ci, input logic s, input logic q, input logic [31:0] l);
        for (int k = 0; k < n; k++) begin
            vec_t v;
            v.start = st; v.stop = sp; v.cnt = c; v.rep = r;
            v.busy = b; v.en = e; v.idx = i; v.chk_idx = ci;
            v.step = s; v.seq = q; v.load = l;
            rows.push_back(v);
        end
    endtask

    // Each row: check this cycle's outputs, drive this cycle's inputs, advance.
    task automatic run_rows(input string tag);
        for (int r = 0; r < rows.size(); r++) begin
            vec_t v;
            v = rows[r];
            start       = v.start;
            stop        = v.stop;
            count       = v.cnt;
            repeat_mode = v.rep;
            chk($sformatf("%s row %0d busy/en/step/seq/load", tag, r),
                {28'd0, busy, tmr_enable, step_done, seq_done, tmr_load},
                {28'd0, v.busy, v.en, v.step, v.seq, v.load});
            if (v.chk_idx) chk($sformatf("%s row %0d idx", tag, r), 64'(step_idx), 64'(v.idx));
            tick();
        end
        start = 1'b0;
        stop  = 1'b0;
        rows.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk("reset outputs", {24'd0, tmr_enable, busy, step_idx, step_done, seq_done, err, tmr_load},
            64'd0);
        rst = 1'b1;
        tick();

        // Table {5,0,3}, count 3, no repeat: periods 8, 3, 6
        wr(2'd0, 32'd5);
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd3);
        add(1, 1, 0, 3'd3, 0, 0, 0, 2'd0, 1, 0, 0, 32'd0);  // N
        add(1, 0, 0, 3'd3, 0, 1, 0, 2'd0, 1, 0, 0, 32'd5);  // N+1 LOAD
        add(7, 0, 0, 3'd3, 0, 1, 1, 2'd0, 1, 0, 0, 32'd5);  // N+2..N+8 RUN
        add(1, 0, 0, 3'd3, 0, 1, 0, 2'd1, 1, 1, 0, 32'd0);  // N+9
        add(2, 0, 0, 3'd3, 0, 1, 1, 2'd1, 1, 0, 0, 32'd0);
        add(1, 0, 0, 3'd3, 0, 1, 0, 2'd2, 1, 1, 0, 32'd3);  // N+12
        add(5, 0, 0, 3'd3, 0, 1, 1, 2'd2, 1, 0, 0, 32'd3);
        add(1, 0, 0, 3'd3, 0, 0, 0, 2'd0, 0, 1, 1, 32'd3);  // N+18
        add(2, 0, 0, 3'd3, 0, 0, 0, 2'd0, 0, 0, 0, 32'd3);
        run_rows("seq3");

        // Table {2,2}, count 2, repeat; config changed after start; stop mid-RUN
        wr(2'd0, 32'd2);
        wr(2'd1, 32'd2);
        add(1, 1, 0, 3'd2, 1, 0, 0, 2'd0, 0, 0, 0, 32'd3);  // N
        add(1, 0, 0, 3'd1, 0, 1, 0, 2'd0, 1, 0, 0, 32'd2);  // N+1 LOAD
        add(4, 0, 0, 3'd1, 0, 1, 1, 2'd0, 1, 0, 0, 32'd2);
        add(1, 0, 0, 3'd1, 0, 1, 0, 2'd1, 1, 1, 0, 32'd2);  // N+6
        add(4, 0, 0, 3'd1, 0, 1, 1, 2'd1, 1, 0, 0, 32'd2);
        add(1, 0, 0, 3'd1, 0, 1, 0, 2'd0, 1, 1, 0, 32'd2);  // N+11
        add(4, 0, 0, 3'd1, 0, 1, 1, 2'd0, 1, 0, 0, 32'd2);
        add(1, 0, 0, 3'd1, 0, 1, 0, 2'd1, 1, 1, 0, 32'd2);  // N+16
        add(1, 0, 0, 3'd1, 0, 1, 1, 2'd1, 1, 0, 0, 32'd2);
        add(1, 0, 1, 3'd1, 0, 1, 1, 2'd1, 1, 0, 0, 32'd2);  // N+18 stop
        add(9, 0, 0, 3'd1, 0, 0, 0, 2'd0, 0, 0, 0, 32'd2);
        run_rows("loop2");

        // Timeout outside RUN is ignored
        use_model = 1'b0;
        count     = 3'd1;
        man_to    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("idle timeout %0d", k), {62'd0, busy, step_done}, 64'd0);
        end
        man_to = 1'b0;

        // stop and timeout in the same RUN cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("stop+to pre en", 64'(tmr_enable), 64'd1);
        man_to = 1'b1;
        stop   = 1'b1;
        tick();
        man_to = 1'b0;
        stop   = 1'b0;
        chk("stop+to after", {60'd0, busy, tmr_enable, step_done, seq_done}, 64'd0);
        tick();
        chk("stop+to later", {61'd0, busy, step_done, seq_done}, 64'd0);

        // count bounds: 0 and DEPTH+1 ignored, DEPTH accepted
        count = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("count0 busy", 64'(busy), 64'd0);
        count = 3'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("count5 busy", 64'(busy), 64'd0);
        tick();
        chk("count5 busy later", 64'(busy), 64'd0);
        count = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("count4 busy", 64'(busy), 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Table write while busy is dropped
        use_model = 1'b1;
        count     = 3'd1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("wr busy load1", tmr_load, 64'd2);
        tick();
        wr(2'd0, 32'd9);
        repeat (3) tick();
        chk("wr busy seq_done", {62'd0, seq_done, busy}, 64'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wr busy load2", tmr_load, 64'd2);
        repeat (5) tick();
        chk("wr busy seq_done2", {62'd0, seq_done, busy}, 64'd2);

        // Reset mid-RUN, then the table reads back as zero
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("midrun reset", {24'd0, tmr_enable, busy, step_idx, step_done, seq_done, err, tmr_load},
            64'd0);
        rst   = 1'b1;
        tick();
        count = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 4; e++) begin
            chk($sformatf("zero table entry %0d", e),
                {28'd0, busy, tmr_enable, step_idx, tmr_load}, {28'd0, 1'b1, 1'b0, 2'(e), 32'd0});
            repeat (3) tick();
        end
        chk("zero table seq_done", {62'd0, seq_done, busy}, 64'd2);

        // Overrun: no timeout, table {4}
        use_model = 1'b0;
        man_to    = 1'b0;
        wr(2'd0, 32'd4);
        count = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        chk("overrun before", {62'd0, busy, err}, 64'd2);
        tick();
`ifdef TIMER_SEQ_OVERRUN_EN
        chk("overrun err", {60'd0, err, busy, tmr_enable, step_done | seq_done}, 64'd8);
        tick();
        chk("overrun err sticky", {62'd0, err, busy}, 64'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("overrun err cleared", {62'd0, err, busy}, 64'd1);
`else
        chk("no overrun", {61'd0, err, busy, tmr_enable}, 64'd3);
        repeat (30) tick();
        chk("no overrun later", {61'd0, err, busy, tmr_enable}, 64'd3);
`endif
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("final idle", {62'd0, busy, tmr_enable}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
